// File: rtl/piso_serializer_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the single-clock PISO serializer:
//   state_e : serializer FSM states (S_IDLE, S_SHIFT)
//   clog2   : ceiling log2, used to size the bit counter and FIFO pointers
// -----------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    // Smallest r with 2**r >= value (returns 0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// -----------------------------------------------------------------------------
// piso_serializer_if
// Bundles the parallel-side and serial-side handshakes of the serializer.
//   data_i  [WIDTH]  parallel word          (producer -> block)
//   valid_i          data_i valid           (producer -> block)
//   ready_o          block can take a word  (block -> producer)
//   data_o           current serial bit     (block -> consumer)
//   valid_o          data_o valid           (block -> consumer)
//   last_o           final bit of its word  (block -> consumer)
//   ready_i          consumer takes data_o  (consumer -> block)
//   level_o [LVL_W]  words waiting in FIFO  (block -> observer)
// Modports: slave = the serializer, master = the surrounding environment.
// -----------------------------------------------------------------------------
interface piso_serializer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    import piso_pkg::*;

    localparam int LVL_W = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic             data_o;
    logic             valid_o;
    logic             last_o;
    logic             ready_i;
    logic [LVL_W-1:0] level_o;

    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, data_o, valid_o, last_o, level_o
    );

    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o, last_o, level_o
    );

endinterface

// File: rtl/piso_serializer_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. Pointers carry one extra MSB so
// full and empty are told apart without a separate counter.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   wr_data_i/wr_en_i : write port (ignored while full)
//   rd_en_i           : pop the head (ignored while empty)
//   rd_data_o         : head word, valid whenever empty_o is low
//   full_o, empty_o, level_o : occupancy status
// -----------------------------------------------------------------------------
module sync_fifo
    import piso_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     wr_en_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [clog2(DEPTH):0]    level_o
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_wr;
    logic             w_rd;

    assign full_o    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty_o   = (r_wptr == r_rptr);
    assign level_o   = r_wptr - r_rptr;
    assign rd_data_o = r_mem[r_rptr[AW-1:0]];
    assign w_wr      = wr_en_i && !full_o;
    assign w_rd      = rd_en_i && !empty_o;

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= wr_data_i;
        end
    end

    // Read/write pointer advance.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wptr <= {(AW+1){1'b0}};
            r_rptr <= {(AW+1){1'b0}};
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_rd) begin
                r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Single-clock parallel-in/serial-out block. Words enter a DEPTH-entry FWFT
// FIFO and are shifted out one bit per accepted serial beat, LSB first
// (MSB_FIRST=0) or MSB first (MSB_FIRST=1), with last_o on the final bit.
// The next word is loaded on the same edge the last bit is taken, so
// back-to-back words stream without a bubble.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset; discards shifter and FIFO
//   bus     : piso_serializer_if slave modport (parallel + serial handshakes)
// -----------------------------------------------------------------------------
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    piso_serializer_if.slave    bus
);

    localparam int CNT_W   = clog2(WIDTH);
    localparam int LVL_W   = clog2(DEPTH) + 1;
    localparam int OUT_BIT = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_pop;
    logic             w_ready;
    logic             w_push;
    logic             w_last;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [WIDTH-1:0] w_fifo_head;
    logic [LVL_W-1:0] w_level;

    // Gating with rst_n_i keeps ready_o low for the whole reset window.
    assign w_ready = rst_n_i && !w_fifo_full;
    assign w_push  = bus.valid_i && w_ready;
    assign w_last  = (r_state == S_SHIFT) && (r_count == CNT_W'(WIDTH - 1));

    assign bus.ready_o = w_ready;
    assign bus.valid_o = (r_state == S_SHIFT);
    assign bus.data_o  = (r_state == S_SHIFT) && r_shreg[OUT_BIT];
    assign bus.last_o  = w_last;
    assign bus.level_o = w_level;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_data_i (bus.data_i),
        .wr_en_i   (w_push),
        .rd_en_i   (w_pop),
        .rd_data_o (w_fifo_head),
        .full_o    (w_fifo_full),
        .empty_o   (w_fifo_empty),
        .level_o   (w_level)
    );

    // Next-state, shifter and counter update; pops the FIFO when loading.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_count_nxt = r_count;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shreg_nxt = w_fifo_head;
                    w_count_nxt = {CNT_W{1'b0}};
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (bus.ready_i) begin
                    if (w_last) begin
                        if (!w_fifo_empty) begin
                            // Reload on the last beat so words stay contiguous.
                            w_pop       = 1'b1;
                            w_shreg_nxt = w_fifo_head;
                            w_count_nxt = {CNT_W{1'b0}};
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        if (MSB_FIRST != 0) begin
                            w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
                        end else begin
                            w_shreg_nxt = {1'b0, r_shreg[WIDTH-1:1]};
                        end
                        w_count_nxt = r_count + CNT_W'(1'b1);
                    end
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state, shift register and bit counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_shreg <= {WIDTH{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Drives an LSB-first and an MSB-first serializer with identical stimulus and
// compares both serial streams against a word-queue reference model.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] data_i;
    logic         valid_i;
    logic         ready_i;

    int n_checks = 0;
    int n_fail   = 0;

    piso_serializer_if #(.WIDTH(W), .DEPTH(D)) bus_l ();
    piso_serializer_if #(.WIDTH(W), .DEPTH(D)) bus_m ();

    assign bus_l.data_i  = data_i;
    assign bus_l.valid_i = valid_i;
    assign bus_l.ready_i = ready_i;
    assign bus_m.data_i  = data_i;
    assign bus_m.valid_i = valid_i;
    assign bus_m.ready_i = ready_i;

    piso_serializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) dut_l (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_l)
    );

    piso_serializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) dut_m (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: every accepted word in order, plus the bit position
    // reached in the head word.
    logic [W-1:0] q[$];
    int           bit_idx    = 0;
    int           n_words_out = 0;
    bit           prev_stall = 1'b0;
    logic         prev_d_l, prev_d_m, prev_last_l, prev_last_m;

    typedef struct packed {
        logic [W-1:0] word;
        logic [W-1:0] seq_l;   // seq[i] = i-th serial bit, LSB-first DUT
        logic [W-1:0] seq_m;   // seq[i] = i-th serial bit, MSB-first DUT
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        bit_idx    = 0;
        prev_stall = 1'b0;
    endtask

    // Called at a falling edge with inputs already set: checks outputs against
    // the model, books the transfers of the coming rising edge, advances a cycle.
    task automatic step();
        bit push, beat;
        if (prev_stall) begin
            check("stall_data_l", bus_l.data_o, prev_d_l);
            check("stall_data_m", bus_m.data_o, prev_d_m);
            check("stall_last_l", bus_l.last_o, prev_last_l);
            check("stall_last_m", bus_m.last_o, prev_last_m);
        end
        if (bus_l.valid_o || bus_m.valid_o) begin
            if (q.size() == 0) begin
                check("spurious_valid", bus_l.valid_o | bus_m.valid_o, 0);
            end else begin
                check("data_l", bus_l.data_o, q[0][bit_idx]);
                check("data_m", bus_m.data_o, q[0][W-1-bit_idx]);
                check("last_l", bus_l.last_o, bit_idx == W - 1);
                check("last_m", bus_m.last_o, bit_idx == W - 1);
            end
        end
        push = valid_i && bus_l.ready_o;
        beat = bus_l.valid_o && ready_i && (q.size() > 0);
        if (beat) begin
            if (bit_idx == W - 1) begin
                void'(q.pop_front());
                bit_idx = 0;
                n_words_out++;
            end else begin
                bit_idx++;
            end
        end
        if (push) q.push_back(data_i);
        prev_stall  = bus_l.valid_o && !ready_i;
        prev_d_l    = bus_l.data_o;
        prev_d_m    = bus_m.data_o;
        prev_last_l = bus_l.last_o;
        prev_last_m = bus_m.last_o;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One isolated word with ready_i high: latency, bit sequence, last marker.
    task automatic apply_vec(input vec_t v);
        data_i  = v.word;
        valid_i = 1'b1;
        ready_i = 1'b1;
        step();
        valid_i = 1'b0;
        check("lat_valid_after_push", bus_l.valid_o, 0);
        check("lat_level_after_push", bus_l.level_o, 1);
        step();
        check("lat_level_after_load", bus_l.level_o, 0);
        for (int b = 0; b < W; b++) begin
            check("vec_valid", bus_l.valid_o, 1);
            check("vec_bit_l", bus_l.data_o, v.seq_l[b]);
            check("vec_bit_m", bus_m.data_o, v.seq_m[b]);
            check("vec_last", bus_l.last_o, b == W - 1);
            step();
        end
        check("vec_idle_after", bus_l.valid_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pushed;
        int guard;

        rst_n   = 1'b0;
        data_i  = '0;
        valid_i = 1'b0;
        ready_i = 1'b0;

        vecs[0] = '{word: 8'hA5, seq_l: 8'hA5, seq_m: 8'hA5};
        vecs[1] = '{word: 8'h80, seq_l: 8'h80, seq_m: 8'h01};
        vecs[2] = '{word: 8'h01, seq_l: 8'h01, seq_m: 8'h80};
        vecs[3] = '{word: 8'hC8, seq_l: 8'hC8, seq_m: 8'h13};
        vecs[4] = '{word: 8'h3C, seq_l: 8'h3C, seq_m: 8'h3C};

        // Reset values
        #2;
        check("rst_ready", bus_l.ready_o, 0);
        check("rst_valid", bus_l.valid_o, 0);
        check("rst_data", bus_l.data_o, 0);
        check("rst_last", bus_l.last_o, 0);
        check("rst_level", bus_l.level_o, 0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", bus_l.ready_o, 1);
        check("post_rst_valid", bus_l.valid_o, 0);

        // Table of isolated words
        for (int i = 0; i < 5; i++) begin
            apply_vec(vecs[i]);
        end

        // Fill: one word to the shifter, four to the FIFO, sixth refused
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_i  = 8'(8'h11 * (i + 1));
            valid_i = 1'b1;
            step();
        end
        check("full_level", bus_l.level_o, 4);
        check("full_ready", bus_l.ready_o, 0);
        check("full_valid", bus_l.valid_o, 1);
        data_i = 8'hEE;
        step();
        check("refused_level", bus_l.level_o, 4);
        check("refused_qsize", q.size(), 5);
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            step();
            if (j == 7) check("ready_before_pop", bus_l.ready_o, 0);
            if (j == 8) check("ready_after_pop", bus_l.ready_o, 1);
            if (j < 40) check("drain_contig_valid", bus_l.valid_o, 1);
        end
        check("drain_idle", bus_l.valid_o, 0);
        check("drain_words", q.size(), 0);

        // Streaming: push exactly on each last beat, level stays at 1
        ready_i = 1'b1;
        data_i  = 8'h5A; valid_i = 1'b1; step();
        data_i  = 8'hC3; valid_i = 1'b1; step();
        for (int j = 0; j < 40; j++) begin
            valid_i = bus_l.last_o;
            data_i  = 8'($urandom);
            step();
            check("stream_level", bus_l.level_o, 1);
            check("stream_valid", bus_l.valid_o, 1);
        end
        valid_i = 1'b0;
        guard = 0;
        while ((q.size() != 0 || bus_l.valid_o) && guard < 200) begin
            step();
            guard++;
        end
        check("stream_drained", q.size(), 0);

        // Random traffic with stalls
        n_words_out = 0;
        pushed      = 0;
        guard       = 0;
        while (pushed < 100 && guard < 20000) begin
            valid_i = ($urandom_range(0, 3) != 0);
            data_i  = 8'($urandom);
            ready_i = ($urandom_range(0, 2) != 0);
            if (valid_i && bus_l.ready_o) pushed++;
            step();
            guard++;
        end
        valid_i = 1'b0;
        guard   = 0;
        while ((q.size() != 0 || bus_l.valid_o) && guard < 5000) begin
            ready_i = ($urandom_range(0, 2) != 0);
            step();
            guard++;
        end
        check("rand_pushed", pushed, 100);
        check("rand_words_out", n_words_out, 100);
        check("rand_drained", q.size(), 0);

        // Asynchronous reset mid-word (bit 3) with two words queued
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_i  = 8'hFF;
            valid_i = 1'b1;
            step();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        ready_i = 1'b0;
        check("pre_rst_level", bus_l.level_o, 2);
        check("pre_rst_data", bus_l.data_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus_l.valid_o, 0);
        check("mid_rst_data_l", bus_l.data_o, 0);
        check("mid_rst_data_m", bus_m.data_o, 0);
        check("mid_rst_last", bus_l.last_o, 0);
        check("mid_rst_level", bus_l.level_o, 0);
        check("mid_rst_ready", bus_l.ready_o, 0);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", bus_l.ready_o, 1);
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_stale_valid", bus_l.valid_o, 0);
        end
        apply_vec(vecs[4]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
